// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

    // Ceiling log2 with a floor of 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Valid/ready request and result channels of the binary-to-BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  bcd_neg;
    logic                  busy;

    modport master (
        output in_valid, bin_in, out_ready,
        input  in_ready, out_valid, bcd_out, bcd_neg, busy
    );

    modport slave (
        input  in_valid, bin_in, out_ready,
        output in_ready, out_valid, bcd_out, bcd_neg, busy
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: add 3 to any digit of 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    output logic [BCD_DIGIT_W-1:0] q
);
    always_comb begin
        q = (d >= ADD3_THRESH) ? d + BCD_DIGIT_W'(3) : d;
    end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3), valid/ready on both sides.
// Define SIGNED_INPUT_EN to treat bin_in as two's complement and report the sign on bcd_neg.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input logic              clk,
    input logic              rst_n,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = clog2(BIN_W + 1);

    if (!((64'd10 ** DIGITS) > ((64'd1 << BIN_W) - 64'd1))) begin : g_bad_cfg
        $error("bin_to_bcd_seq: DIGITS too small to hold 2**BIN_W-1");
    end

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [BCD_W-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d, res_neg_q, res_neg_d;
    logic [BIN_W-1:0]   mag;
    logic               sign_in;

`ifdef SIGNED_INPUT_EN
    // Negating the most negative value wraps to 2**(BIN_W-1), read back as unsigned.
    assign sign_in = bus.bin_in[BIN_W-1];
    assign mag     = sign_in ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;
`else
    assign sign_in = 1'b0;
    assign mag     = bus.bin_in;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (bcd_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        res_d     = res_q;
        res_neg_d = res_neg_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    bin_d   = mag;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    neg_d   = sign_in;
                    state_d = StShift;
                end
            end
            StShift: begin
                // The cycle after the last shift publishes the result into the output register.
                if (cnt_q == CNT_W'(BIN_W)) begin
                    res_d     = bcd_q;
                    res_neg_d = neg_q;
                    state_d   = StDone;
                end else begin
                    {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                    cnt_d          = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            res_q     <= '0;
            res_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            res_q     <= res_d;
            res_neg_q <= res_neg_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.bcd_out   = res_q;
    assign bus.bcd_neg   = res_neg_q;
endmodule
